biquad_stream_ctrl: RTL
=======================

// Module: biquad_stream_ctrl
// PURPOSE
//  Streaming front/back end for one biquad IIR section. Accepts samples on a
//  valid/ready input and issues the section's x/valid strobe at a programmed
//  rate, so multicycle multipliers can be used. Holds shadowed coefficients
//  with an atomic commit. Captures the section's yout into an output FIFO.
// PARAMETERS
//  DATAWIDTH     16  input sample width (matches section x)
//  COEFWIDTH     16  coefficient and output (yout) width
//  STROBE_DIV    4   clocks per strobe slot, >=1 (1 = strobe every clock)
//  PIPE_STROBES  9   strobes from sample issue until yout is meaningful
//  FIFO_DEPTH    4   output FIFO entries, power of 2, >=2
// PORTS
//  clk        in   1            clock
//  nreset     in   1            async active-low reset
//  enable     in   1            run; low = strobe counter held at 0, no strobes
//  s_data     in   DATAWIDTH    input sample
//  s_valid    in   1            input sample valid
//  s_ready    out  1            = ~hold_full (1-entry input hold register)
//  m_data     out  COEFWIDTH    FIFO head (filtered sample)
//  m_valid    out  1            FIFO not empty
//  m_ready    in   1            consumer pops the head when m_valid & m_ready
//  cfg_we     in   1            config write strobe
//  cfg_addr   in   3            0 b10, 1 b11, 2 b12, 3 a11, 4 a12, 6 flush, 7 clr status
//  cfg_wdata  in   COEFWIDTH    shadow coefficient value (ignored for addr 5/6/7)
//  cfg_commit in   1            request copy of the shadow bank into the active bank
//  bq_x       out  DATAWIDTH    to section x (registered)
//  bq_valid   out  1            to section valid, 1-clock pulse (registered)
//  bq_b10..bq_a12 out COEFWIDTH each  active coefficients to the section
//  bq_yout    in   COEFWIDTH    from section yout
//  ovf        out  1            sticky: a captured output was dropped (FIFO full)
//  udr        out  1            sticky: a strobe slot passed with the hold register empty
// BEHAVIOUR
//  Reset: all registers 0, including the shadow and active banks, bq_*, FIFO
//   pointers, ovf, udr and prime_cnt; s_ready=1, m_valid=0.
//  Slot counter: increments 0..STROBE_DIV-1 and wraps while enable=1.
//   tick = enable & (cnt==STROBE_DIV-1).
//  Issue: on a tick with hold_full=1, the next edge sets bq_x<=hold, bq_valid<=1
//   and hold_full<=0. bq_valid is 0 in every other cycle.
//   Tick with hold empty: no strobe, udr<=1. Slots are skipped, never zero-filled.
//  Input: a sample is accepted when s_valid & s_ready, and hold_full<=1.
//   Because s_ready is ~hold_full, accept and issue never happen in the same cycle.
//  Priming: prime_cnt saturates at PIPE_STROBES and increments on each issued strobe.
//  Capture: in the cycle after bq_valid=1 (yout has updated), if prime_cnt==PIPE_STROBES
//   then push bq_yout. If the FIFO is full, drop the value and set ovf<=1.
//   Latency: sample k is pushed in the cycle after the strobe that issues
//   sample k+PIPE_STROBES-1.
//  FIFO: a push and a pop in the same cycle when full is allowed; the count is unchanged
//   and ovf is not set. A pop when empty is ignored.
//  Coefficients: cfg_we to addr 0-4 writes the shadow bank only. cfg_commit sets
//   commit_pend. The shadow bank is copied to the active bank at the next tick edge,
//   or on the next edge if enable=0; commit_pend then clears. Commit and
//   cfg_we in the same cycle: the new shadow value is included in the copy.
//  addr 6 (flush): clears the FIFO, prime_cnt and hold_full. Coefficients are kept.
//  addr 7: clears ovf and udr. If a set event happens in the same cycle, the set wins.
//  Deasserting enable mid-run: the pending hold sample is kept and prime_cnt is kept.
//   No strobe is issued until enable returns; the slot counter restarts at 0.
//  nreset mid-operation: asynchronously returns every register to the reset state.
// TESTING
//  STROBE_DIV=4, s_valid held 1, 20 samples -> bq_valid every 4th clk, s_ready
//   low only between accept and issue, first m_valid 1 clk after the 9th strobe.
//  Write b10=0x4000 then commit mid-stream -> bq_b10 changes exactly at the next
//   tick edge; with no commit, bq_b10 stays 0 despite the shadow write.
//  m_ready=0, 14 samples issued -> FIFO holds the first 4 outputs (samples 0-3),
//   ovf=1; addr7 write -> ovf=0; draining returns those 4 values in order.
//  s_valid=0 for 3 slots -> udr=1, no bq_valid; resume -> strobes restart on the
//   next tick.
//  enable dropped with hold full, then raised -> the held sample is issued on the
//   4th clk after enable rises; prime_cnt is unchanged.
//  Assert nreset while the FIFO holds 3 entries -> m_valid=0, s_ready=1, all bq_*=0
//   immediately.

Source files
------------

// File: rtl/biquad_stream_ctrl.sv
// biquad_stream_ctrl: streaming front/back end for one biquad IIR section.
// A one-entry hold register feeds the section at a programmed strobe rate.
// Coefficients are double-buffered with an atomic commit. Section outputs go
// into a small FIFO once the section pipeline is primed.
//
// Handshake semantics (both stream ports): a transfer happens on a rising edge
// where valid and ready are both high. Valid never depends on ready.
// s_ready is ~hold_full. m_valid is FIFO not-empty.
module biquad_stream_ctrl #(
  parameter int DATAWIDTH    = 16,
  parameter int COEFWIDTH    = 16,
  parameter int STROBE_DIV   = 4,
  parameter int PIPE_STROBES = 9,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                 clk,
  input  logic                 nreset,
  input  logic                 enable,
  input  logic [DATAWIDTH-1:0] s_data,
  input  logic                 s_valid,
  output logic                 s_ready,
  output logic [COEFWIDTH-1:0] m_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  input  logic                 cfg_we,
  input  logic [2:0]           cfg_addr,
  input  logic [COEFWIDTH-1:0] cfg_wdata,
  input  logic                 cfg_commit,
  output logic [DATAWIDTH-1:0] bq_x,
  output logic                 bq_valid,
  output logic [COEFWIDTH-1:0] bq_b10,
  output logic [COEFWIDTH-1:0] bq_b11,
  output logic [COEFWIDTH-1:0] bq_b12,
  output logic [COEFWIDTH-1:0] bq_a11,
  output logic [COEFWIDTH-1:0] bq_a12,
  input  logic [COEFWIDTH-1:0] bq_yout,
  output logic                 ovf,
  output logic                 udr
);

  localparam int SLOT_W  = (STROBE_DIV > 1) ? $clog2(STROBE_DIV) : 1;
  localparam int PRIME_W = $clog2(PIPE_STROBES + 1);
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int NCOEF   = 5;

  logic [SLOT_W-1:0]                   slot_q, slot_d;
  logic [DATAWIDTH-1:0]                hold_q, hold_d;
  logic                                hold_full_q, hold_full_d;
  logic [DATAWIDTH-1:0]                bq_x_q, bq_x_d;
  logic                                bq_valid_q, bq_valid_d;
  logic                                cap_q, cap_d;
  logic [PRIME_W-1:0]                  prime_q, prime_d;
  logic [NCOEF-1:0][COEFWIDTH-1:0]     shadow_q, shadow_d;
  logic [NCOEF-1:0][COEFWIDTH-1:0]     active_q, active_d;
  logic                                commit_pend_q, commit_pend_d;
  logic [FIFO_DEPTH-1:0][COEFWIDTH-1:0] mem_q, mem_d;
  logic [PTR_W:0]                      wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]                      rd_ptr_q, rd_ptr_d;
  logic                                ovf_q, ovf_d;
  logic                                udr_q, udr_d;

  logic tick, issue, accept, flush, clr_status;
  logic fifo_empty, fifo_full, pop, push_req, push, drop;
  logic commit_now, do_commit;

  assign tick       = enable && (slot_q == SLOT_W'(STROBE_DIV - 1));
  assign issue      = tick && hold_full_q;
  assign accept     = s_valid && !hold_full_q;
  assign flush      = cfg_we && (cfg_addr == 3'd6);
  assign clr_status = cfg_we && (cfg_addr == 3'd7);

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                      (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign pop        = m_ready && !fifo_empty;
  // cap_q marks the cycle after the strobe, when the section's yout is fresh.
  assign push_req   = cap_q && (prime_q == PRIME_W'(PIPE_STROBES)) && !flush;
  assign push       = push_req && (!fifo_full || pop);
  assign drop       = push_req && fifo_full && !pop;

  // A commit request arriving with a same-cycle shadow write copies the new value.
  assign commit_now = commit_pend_q || cfg_commit;
  assign do_commit  = commit_now && (tick || !enable);

  // Next-state logic for slot timing, hold register, strobe, FIFO and config.
  always_comb begin
    slot_d        = (!enable || tick) ? '0 : slot_q + 1'b1;
    hold_d        = hold_q;
    hold_full_d   = hold_full_q;
    bq_x_d        = bq_x_q;
    bq_valid_d    = issue;
    cap_d         = bq_valid_q;
    prime_d       = prime_q;
    shadow_d      = shadow_q;
    active_d      = active_q;
    commit_pend_d = commit_now && !do_commit;
    mem_d         = mem_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    ovf_d         = drop ? 1'b1 : (clr_status ? 1'b0 : ovf_q);
    udr_d         = (tick && !hold_full_q) ? 1'b1 : (clr_status ? 1'b0 : udr_q);

    if (issue) begin
      bq_x_d      = hold_q;
      hold_full_d = 1'b0;
    end else if (accept) begin
      hold_d      = s_data;
      hold_full_d = 1'b1;
    end

    if (issue && (prime_q != PRIME_W'(PIPE_STROBES))) begin
      prime_d = prime_q + 1'b1;
    end

    if (push) begin
      mem_d[wr_ptr_q[PTR_W-1:0]] = bq_yout;
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end

    // Flush drops queued work but leaves coefficients and status alone.
    if (flush) begin
      hold_full_d = 1'b0;
      prime_d     = '0;
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
    end

    for (int i = 0; i < NCOEF; i++) begin
      if (cfg_we && (cfg_addr == 3'(i))) begin
        shadow_d[i] = cfg_wdata;
      end
    end
    if (do_commit) begin
      active_d = shadow_d;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      slot_q        <= '0;
      hold_q        <= '0;
      hold_full_q   <= 1'b0;
      bq_x_q        <= '0;
      bq_valid_q    <= 1'b0;
      cap_q         <= 1'b0;
      prime_q       <= '0;
      shadow_q      <= '0;
      active_q      <= '0;
      commit_pend_q <= 1'b0;
      mem_q         <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      ovf_q         <= 1'b0;
      udr_q         <= 1'b0;
    end else begin
      slot_q        <= slot_d;
      hold_q        <= hold_d;
      hold_full_q   <= hold_full_d;
      bq_x_q        <= bq_x_d;
      bq_valid_q    <= bq_valid_d;
      cap_q         <= cap_d;
      prime_q       <= prime_d;
      shadow_q      <= shadow_d;
      active_q      <= active_d;
      commit_pend_q <= commit_pend_d;
      mem_q         <= mem_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      ovf_q         <= ovf_d;
      udr_q         <= udr_d;
    end
  end

  assign s_ready  = !hold_full_q;
  assign m_valid  = !fifo_empty;
  assign m_data   = mem_q[rd_ptr_q[PTR_W-1:0]];
  assign bq_x     = bq_x_q;
  assign bq_valid = bq_valid_q;
  assign bq_b10   = active_q[0];
  assign bq_b11   = active_q[1];
  assign bq_b12   = active_q[2];
  assign bq_a11   = active_q[3];
  assign bq_a12   = active_q[4];
  assign ovf      = ovf_q;
  assign udr      = udr_q;

endmodule
